// File: rtl/dma_csr_bank.sv
// Per-channel CONTROL/STATUS/DESC_PTR register bank behind an Avalon-style CSR slave.
// Adds a self-clearing GO pulse, W1C engine event bits and an aggregated registered interrupt.
module dma_csr_bank #(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [31:0] DESC_RST = 32'h0,
  localparam int unsigned CH_AW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   csr_wr_i,
  input  logic                   csr_rd_i,
  input  logic [CH_AW+3:0]       csr_addr_i,
  input  logic [31:0]            csr_wr_data_i,
  input  logic [3:0]             csr_be_i,
  output logic                   csr_wait_rq_o,
  output logic [31:0]            csr_rd_data_o,
  output logic [NUM_CH-1:0]      ch_go_o,
  output logic [NUM_CH*32-1:0]   ch_desc_ptr_o,
  input  logic [NUM_CH-1:0]      ch_busy_i,
  input  logic [NUM_CH-1:0]      ch_done_i,
  input  logic [NUM_CH-1:0]      ch_err_i,
  output logic                   irq_o
);

  typedef enum logic [1:0] {StIdle, StWrAck, StRdWait, StRdAck} state_e;

  state_e             state_q;
  logic [CH_AW+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        rd_data_q;
  logic               wait_q;

  logic [31:0]        ctrl_q [NUM_CH];
  logic [31:0]        desc_q [NUM_CH];
  logic [NUM_CH-1:0]  done_q, err_q, go_q;
  logic               irq_q;

  logic [CH_AW-1:0]   ch_sel;
  logic [1:0]         reg_sel;
  logic [31:0]        be_mask;
  logic [31:0]        rd_mux;
  logic [NUM_CH-1:0]  wr_hit, clr_done, clr_err, irq_src;
  logic               unused_addr;

  // Word offset bits only; the byte lane within a word is not decoded.
  assign unused_addr = ^csr_addr_i[1:0];

  always_comb begin
    ch_sel  = addr_q[CH_AW+1:2];
    reg_sel = addr_q[1:0];
    be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    rd_mux  = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      wr_hit[n]   = (state_q == StWrAck) && (32'(ch_sel) == n);
      clr_done[n] = wr_hit[n] && (reg_sel == 2'd1) && be_q[0] && wdata_q[1];
      clr_err[n]  = wr_hit[n] && (reg_sel == 2'd1) && be_q[0] && wdata_q[2];
      irq_src[n]  = ctrl_q[n][1] & (done_q[n] | err_q[n]);
      if (32'(ch_sel) == n) begin
        case (reg_sel)
          2'd0:    rd_mux = ctrl_q[n];
          2'd1:    rd_mux = {29'd0, err_q[n], done_q[n], ch_busy_i[n]};
          2'd2:    rd_mux = desc_q[n];
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wait_q    <= 1'b1;
      rd_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // A simultaneous read is dropped; the host re-issues it.
          if (csr_wr_i) begin
            addr_q  <= csr_addr_i[CH_AW+3:2];
            wdata_q <= csr_wr_data_i;
            be_q    <= csr_be_i;
            wait_q  <= 1'b0;
            state_q <= StWrAck;
          end else if (csr_rd_i) begin
            addr_q  <= csr_addr_i[CH_AW+3:2];
            state_q <= StRdWait;
          end
        end
        StWrAck: begin
          wait_q  <= 1'b1;
          state_q <= StIdle;
        end
        StRdWait: begin
          rd_data_q <= rd_mux;
          wait_q    <= 1'b0;
          state_q   <= StRdAck;
        end
        default: begin
          wait_q  <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        ctrl_q[n] <= '0;
        desc_q[n] <= DESC_RST;
      end
      done_q <= '0;
      err_q  <= '0;
      go_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      go_q  <= '0;
      irq_q <= |irq_src;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (wr_hit[n] && reg_sel == 2'd0) begin
          // GO is not stored; it only launches a pulse when the engine is idle.
          ctrl_q[n] <= ((ctrl_q[n] & ~be_mask) | (wdata_q & be_mask)) & 32'hFFFF_FFFE;
          go_q[n]   <= be_q[0] & wdata_q[0] & ~ch_busy_i[n];
        end
        if (wr_hit[n] && reg_sel == 2'd2) begin
          desc_q[n] <= (desc_q[n] & ~be_mask) | (wdata_q & be_mask);
        end
        // Engine set pulse overrides a coincident clear.
        done_q[n] <= ch_done_i[n] | (done_q[n] & ~clr_done[n]);
        err_q[n]  <= ch_err_i[n] | (err_q[n] & ~clr_err[n]);
      end
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      ch_desc_ptr_o[32*n +: 32] = desc_q[n];
    end
  end

  assign csr_wait_rq_o = wait_q;
  assign csr_rd_data_o = rd_data_q;
  assign ch_go_o       = go_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_dma_csr_bank.sv
// Directed bench for dma_csr_bank: behavioural register model plus a per-cycle output compare,
// with a second NUM_CH=5 instance to reach an out-of-range channel.
module tb_dma_csr_bank;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         csr_wr, csr_rd, wait_rq, irq;
  logic [5:0]   csr_addr;
  logic [31:0]  wdata, rdata;
  logic [3:0]   be, go, busy, done, err;
  logic [127:0] desc;

  logic         wr5, rd5, wait5, irq5;
  logic [6:0]   addr5;
  logic [31:0]  wdata5, rdata5;
  logic [4:0]   go5;
  logic [4:0]   zero5 = '0;
  logic [159:0] desc5;

  dma_csr_bank #(.NUM_CH(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .csr_wr_i(csr_wr), .csr_rd_i(csr_rd),
    .csr_addr_i(csr_addr), .csr_wr_data_i(wdata), .csr_be_i(be),
    .csr_wait_rq_o(wait_rq), .csr_rd_data_o(rdata), .ch_go_o(go),
    .ch_desc_ptr_o(desc), .ch_busy_i(busy), .ch_done_i(done), .ch_err_i(err),
    .irq_o(irq)
  );

  dma_csr_bank #(.NUM_CH(5), .DESC_RST(32'h1234_5678)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .csr_wr_i(wr5), .csr_rd_i(rd5),
    .csr_addr_i(addr5), .csr_wr_data_i(wdata5), .csr_be_i(4'hF),
    .csr_wait_rq_o(wait5), .csr_rd_data_o(rdata5), .ch_go_o(go5),
    .ch_desc_ptr_o(desc5), .ch_busy_i(zero5), .ch_done_i(zero5), .ch_err_i(zero5),
    .irq_o(irq5)
  );

  // Behavioural model of the four-channel instance
  logic [31:0] m_ctrl [4];
  logic [31:0] m_desc [4];
  logic [3:0]  m_done, m_err, exp_go;
  logic        exp_irq, commit_pending, chk_en;
  logic [5:0]  c_addr;
  logic [31:0] c_data;
  logic [3:0]  c_be;
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int ch;
    ch = int'(a[5:4]);
    case (a[3:2])
      2'd0:    return m_ctrl[ch];
      2'd1:    return {29'd0, m_err[ch], m_done[ch], busy[ch]};
      2'd2:    return m_desc[ch];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_ctrl[n] = '0;
      m_desc[n] = '0;
    end
    m_done = '0; m_err = '0; exp_go = '0; exp_irq = 1'b0; commit_pending = 1'b0;
  endtask

  // Advance one clock edge and update the model with what that edge does.
  task automatic tick();
    logic [3:0] pd, pe, pb;
    logic       pc;
    int         ch;
    pd = done; pe = err; pb = busy; pc = 1'b0;
    for (int n = 0; n < 4; n++) pc = pc | (m_ctrl[n][1] & (m_done[n] | m_err[n]));
    @(posedge clk);
    exp_irq = pc;
    exp_go  = '0;
    if (commit_pending) begin
      ch = int'(c_addr[5:4]);
      case (c_addr[3:2])
        2'd0: begin
          m_ctrl[ch] = merge(m_ctrl[ch], c_data, c_be) & 32'hFFFF_FFFE;
          if (c_be[0] && c_data[0] && !pb[ch]) exp_go[ch] = 1'b1;
        end
        2'd1: if (c_be[0]) begin
          if (c_data[1]) m_done[ch] = 1'b0;
          if (c_data[2]) m_err[ch] = 1'b0;
        end
        2'd2: m_desc[ch] = merge(m_desc[ch], c_data, c_be);
        default: ;
      endcase
      commit_pending = 1'b0;
    end
    m_done = m_done | pd;
    m_err  = m_err | pe;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("go", {28'd0, go}, {28'd0, exp_go});
      chk("irq", {31'd0, irq}, {31'd0, exp_irq});
      for (int n = 0; n < 4; n++) chk("desc_ptr", desc[32*n +: 32], m_desc[n]);
    end
  end

  task automatic idle();
    tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic [3:0] dp);
    csr_wr = 1'b1; csr_addr = a; wdata = d; be = b;
    tick();
    @(negedge clk);
    chk("wr_ack", {31'd0, wait_rq}, 32'd0);
    done = dp;
    commit_pending = 1'b1; c_addr = a; c_data = d; c_be = b;
    tick();
    @(negedge clk);
    csr_wr = 1'b0; done = '0;
    chk("wr_idle", {31'd0, wait_rq}, 32'd1);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] got);
    logic [31:0] e;
    csr_rd = 1'b1; csr_addr = a;
    tick();
    @(negedge clk);
    chk("rd_wait", {31'd0, wait_rq}, 32'd1);
    e = model_read(a);
    tick();
    @(negedge clk);
    chk("rd_ack", {31'd0, wait_rq}, 32'd0);
    chk("rd_data", rdata, e);
    got = rdata;
    tick();
    @(negedge clk);
    csr_rd = 1'b0;
    chk("rd_idle", {31'd0, wait_rq}, 32'd1);
  endtask

  task automatic w5(input logic [6:0] a, input logic [31:0] d);
    wr5 = 1'b1; addr5 = a; wdata5 = d;
    tick();
    @(negedge clk);
    chk("wr5_ack", {31'd0, wait5}, 32'd0);
    tick();
    @(negedge clk);
    wr5 = 1'b0;
    chk("wr5_go", {27'd0, go5}, 32'd0);
  endtask

  task automatic r5(input logic [6:0] a, input logic [31:0] e);
    rd5 = 1'b1; addr5 = a;
    tick();
    @(negedge clk);
    chk("rd5_wait", {31'd0, wait5}, 32'd1);
    tick();
    @(negedge clk);
    chk("rd5_ack", {31'd0, wait5}, 32'd0);
    chk("rd5_data", rdata5, e);
    tick();
    @(negedge clk);
    rd5 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    csr_wr = 0; csr_rd = 0; csr_addr = '0; wdata = '0; be = '0;
    busy = '0; done = '0; err = '0; chk_en = 1'b0;
    wr5 = 0; rd5 = 0; addr5 = '0; wdata5 = '0;
    model_reset();
    #12;
    chk("rst_wait", {31'd0, wait_rq}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_go", {28'd0, go}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    rd(6'h28, v);                      chk("desc2_rst", v, 32'h0);
    wr(6'h28, 32'hDEAD_BEEF, 4'b0101, 4'b0000);
    rd(6'h28, v);                      chk("desc2_be", v, 32'h00AD_00EF);

    wr(6'h10, 32'h3, 4'hF, 4'b0000);
    chk("go_pulse", {28'd0, go}, 32'h2);
    idle();
    chk("go_clear", {28'd0, go}, 32'h0);
    rd(6'h10, v);                      chk("ctrl1", v, 32'h2);
    busy = 4'b0010;
    wr(6'h10, 32'h3, 4'hF, 4'b0000);
    chk("go_busy", {28'd0, go}, 32'h0);
    rd(6'h14, v);                      chk("stat1_busy", v, 32'h1);
    busy = 4'b0000;

    wr(6'h00, 32'h2, 4'b0001, 4'b0000);
    done = 4'b0001;
    idle();
    done = 4'b0000;
    idle();
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(6'h04, v);                      chk("stat0_done", v, 32'h2);
    wr(6'h04, 32'h2, 4'b0001, 4'b0001);
    rd(6'h04, v);                      chk("stat0_setwins", v, 32'h2);
    wr(6'h04, 32'h2, 4'b0001, 4'b0000);
    chk("irq_lag", {31'd0, irq}, 32'd1);
    idle();
    chk("irq_drop", {31'd0, irq}, 32'd0);

    err = 4'b1000;
    idle();
    err = 4'b0000;
    idle();
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd(6'h34, v);                      chk("stat3_err", v, 32'h4);
    wr(6'h34, 32'h4, 4'b1110, 4'b0000);
    rd(6'h34, v);                      chk("stat3_be0off", v, 32'h4);
    wr(6'h34, 32'h4, 4'b0001, 4'b0000);
    rd(6'h34, v);                      chk("stat3_clr", v, 32'h0);

    wr(6'h1C, 32'hFFFF_FFFF, 4'hF, 4'b0000);
    rd(6'h1C, v);                      chk("reserved", v, 32'h0);

    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 6'h08; wdata = 32'hCAFE_F00D; be = 4'hF;
    tick();
    @(negedge clk);
    chk("both_ack", {31'd0, wait_rq}, 32'd0);
    commit_pending = 1'b1; c_addr = 6'h08; c_data = 32'hCAFE_F00D; c_be = 4'hF;
    tick();
    @(negedge clk);
    csr_wr = 1'b0; csr_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("both_noack", {31'd0, wait_rq}, 32'd1);
      idle();
    end
    rd(6'h08, v);                      chk("desc0_both", v, 32'hCAFE_F00D);

    csr_rd = 1'b1; csr_addr = 6'h08;
    tick();
    @(negedge clk);
    chk("rst_rd_wait", {31'd0, wait_rq}, 32'd1);
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wait", {31'd0, wait_rq}, 32'd1);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_desc2", desc[95:64], 32'd0);
    @(negedge clk);
    csr_rd = 1'b0;
    reset_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_noack", {31'd0, wait_rq}, 32'd1);
    end
    rd(6'h28, v);                      chk("desc2_after_rst", v, 32'h0);

    r5(7'h08, 32'h1234_5678);
    w5(7'h50, 32'hFFFF_FFFF);
    w5(7'h58, 32'h0BAD_0BAD);
    for (int n = 0; n < 5; n++) chk("desc5_keep", desc5[32*n +: 32], 32'h1234_5678);
    r5(7'h50, 32'h0);
    r5(7'h58, 32'h0);
    r5(7'h48, 32'h1234_5678);
    chk("irq5", {31'd0, irq5}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
